// File: rtl/spi_resp_pkg.sv
// ============================================================================
// Module   : spi_resp_pkg
// Brief    : Shared constants for the SPI sensor responder (state codes,
//            command-byte fields, default geometry, saturating helper).
// Revision : 1.0
// ============================================================================
`default_nettype none

package spi_resp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

  localparam logic [7:0] DEVICE_ID_DEFAULT = 8'hE5;
  localparam int         ADDR_W_DEFAULT    = 6;

  localparam int CMD_RW_BIT = 7;
  localparam int CMD_MB_BIT = 6;

  // Top address of the default-size register file.
  localparam int ABORT_CNT_ADDR = (1 << ADDR_W_DEFAULT) - 1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_resp_sync.sv
// ============================================================================
// Module   : spi_resp_sync
// Brief    : 2-FF synchronisers for SPI clk/cs/mosi plus registered one-cycle
//            rise/fall strobes; strobes and levels share the same latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_resp_sync (
  input  logic clk,
  input  logic i_spi_clk,
  input  logic i_spi_cs,
  input  logic i_spi_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_cs_rise,
  output logic o_cs_fall,
  output logic o_mosi
);

  // Bit 0 = spi_clk, bit 1 = spi_cs, bit 2 = spi_mosi.
  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic [2:0] r_s3;
  logic [1:0] r_rise;
  logic [1:0] r_fall;

  // No reset: the chain keeps tracking the pins during reset so that a line
  // held low across reset never produces a spurious edge afterwards.
  always_ff @(posedge clk) begin
    r_s1   <= {i_spi_mosi, i_spi_cs, i_spi_clk};
    r_s2   <= r_s1;
    r_s3   <= r_s2;
    r_rise <= r_s2[1:0] & ~r_s3[1:0];
    r_fall <= ~r_s2[1:0] & r_s3[1:0];
  end

  assign o_sclk_rise = r_rise[0];
  assign o_sclk_fall = r_fall[0];
  assign o_cs_rise   = r_rise[1];
  assign o_cs_fall   = r_fall[1];
  assign o_mosi      = r_s3[2];

endmodule

`default_nettype wire

// File: rtl/spi_sensor_responder.sv
// ============================================================================
// Module   : spi_sensor_responder
// Brief    : Mode-3 SPI responder emulating an accelerometer register map.
//            Optional macro SPI_RESP_ABORT_CNT_EN enables the abort counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_sensor_responder
  import spi_resp_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID  = DEVICE_ID_DEFAULT,
  parameter int         ADDR_W     = ADDR_W_DEFAULT,
  parameter logic [7:0] RESET_FILL = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [7:0]        upd_data,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [7:0]        abort_cnt
);

  localparam int c_depth = 1 << ADDR_W;
`ifdef SPI_RESP_ABORT_CNT_EN
  localparam logic [ADDR_W-1:0] c_abort_addr = '1;
`endif

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_mosi;

  spi_resp_sync u_sync (
    .clk         (clk),
    .i_spi_clk   (spi_clk),
    .i_spi_cs    (spi_cs),
    .i_spi_mosi  (spi_mosi),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_cs_rise   (w_cs_rise),
    .o_cs_fall   (w_cs_fall),
    .o_mosi      (w_mosi)
  );

  logic [1:0]        r_state;
  logic [2:0]        r_bitcnt;
  logic [7:0]        r_shift;
  logic              r_mb;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_tx;
  logic              r_miso;
  logic              r_miso_oe;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [7:0]        r_regs [c_depth];
`ifdef SPI_RESP_ABORT_CNT_EN
  logic [7:0]        r_abort_cnt;
`endif

  logic [7:0]        w_shift_nxt;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_byte_done;
  logic              w_spi_we;

  function automatic logic f_writable(input logic [ADDR_W-1:0] a);
`ifdef SPI_RESP_ABORT_CNT_EN
    return (a != '0) && (a != c_abort_addr);
`else
    return a != '0;
`endif
  endfunction

  function automatic logic [7:0] f_read(input logic [ADDR_W-1:0] a);
    logic [7:0] v;
    v = r_regs[a];
    if (a == '0) begin
      v = DEVICE_ID;
    end
`ifdef SPI_RESP_ABORT_CNT_EN
    else if (a == c_abort_addr) begin
      v = r_abort_cnt;
    end
`endif
    return v;
  endfunction

  assign w_shift_nxt = {r_shift[6:0], w_mosi};
  assign w_cmd_addr  = w_shift_nxt[ADDR_W-1:0];
  assign w_addr_nxt  = r_mb ? r_addr + ADDR_W'(1) : r_addr;
  assign w_byte_done = w_sclk_rise && (r_bitcnt == 3'd7) && !w_cs_rise;
  assign w_spi_we    = (r_state == ST_WR) && w_byte_done && f_writable(r_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= 3'd0;
      r_shift    <= 8'h00;
      r_mb       <= 1'b0;
      r_addr     <= '0;
      r_tx       <= 8'h00;
      r_miso     <= 1'b1;
      r_miso_oe  <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
`ifdef SPI_RESP_ABORT_CNT_EN
      r_abort_cnt <= 8'h00;
`endif
    end else begin
      r_wr_valid <= 1'b0;
      if (w_cs_rise) begin
        r_state   <= ST_IDLE;
        r_bitcnt  <= 3'd0;
        r_miso    <= 1'b1;
        r_miso_oe <= 1'b0;
`ifdef SPI_RESP_ABORT_CNT_EN
        if (r_bitcnt != 3'd0) begin
          r_abort_cnt <= sat_inc8(r_abort_cnt);
        end
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            // oe only follows a cs fall seen after reset, so a reset in the
            // middle of a transfer keeps the responder silent until re-armed.
            if (w_cs_fall) begin
              r_state   <= ST_CMD;
              r_bitcnt  <= 3'd0;
              r_miso_oe <= 1'b1;
            end
          end
          ST_CMD: begin
            if (w_sclk_rise) begin
              r_shift  <= w_shift_nxt;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_mb   <= w_shift_nxt[CMD_MB_BIT];
                r_addr <= w_cmd_addr;
                if (w_shift_nxt[CMD_RW_BIT]) begin
                  r_state <= ST_RD;
                  r_tx    <= f_read(w_cmd_addr);
                end else begin
                  r_state <= ST_WR;
                end
              end
            end
          end
          ST_RD: begin
            if (w_sclk_fall) begin
              r_miso <= r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b1};
            end
            if (w_sclk_rise) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_addr <= w_addr_nxt;
                r_tx   <= f_read(w_addr_nxt);
              end
            end
          end
          default: begin
            if (w_sclk_rise) begin
              r_shift  <= w_shift_nxt;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_addr;
                r_wr_data  <= w_shift_nxt;
                r_addr     <= w_addr_nxt;
              end
            end
          end
        endcase
      end
    end
  end

  // The SPI write is the later assignment, so it wins a same-cycle collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_depth; i++) begin
        r_regs[i] <= RESET_FILL;
      end
    end else begin
      if (upd_en && f_writable(upd_addr)) begin
        r_regs[upd_addr] <= upd_data;
      end
      if (w_spi_we) begin
        r_regs[r_addr] <= w_shift_nxt;
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_miso_oe;
  assign wr_valid    = r_wr_valid;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
`ifdef SPI_RESP_ABORT_CNT_EN
  assign abort_cnt   = r_abort_cnt;
`else
  assign abort_cnt   = 8'h00;
`endif

endmodule

`default_nettype wire

// File: doc/spi_sensor_responder.md
Name: spi_sensor_responder

Overview:
- SPI responder (slave) that emulates the 3-wire-select accelerometer register interface driven by the team's SPI initiator.
- Mode 3 (CPOL=1, CPHA=1); 8-bit command byte followed by data bytes, MSB first.
- 64 x 8 register file. Address 0x00 returns the fixed device ID.
- Sits in simulation benches and loop-back FPGA builds in place of the physical sensor; the local side can preload data registers and observe SPI writes.

Parameters:
- DEVICE_ID, 8'hE5, value returned at address 0x00; read-only.
- ADDR_W, 6, register address width; register file depth is 2**ADDR_W.
- RESET_FILL, 8'h00, reset value of every writable register.

Ports:
- clk  input  1  system clock; must be >= 8x spi_clk frequency.
- rst_n  input  1  synchronous active-low reset.
- spi_clk  input  1  SPI clock from the initiator; idles high.
- spi_cs  input  1  chip select, active low.
- spi_mosi  input  1  initiator-to-responder data.
- spi_miso  output  1  responder-to-initiator data.
- spi_miso_oe  output  1  high while spi_cs (synchronised) is low; used for tri-state.
- upd_en  input  1  local register load strobe.
- upd_addr  input  ADDR_W  local load address.
- upd_data  input  8  local load data.
- wr_valid  output  1  one-cycle pulse per completed SPI write byte.
- wr_addr  output  ADDR_W  address of that write.
- wr_data  output  8  data of that write.
- abort_cnt  output  8  aborted-transaction count (see Optional Feature).

Behaviour:
- Synchronisation and edge detection:
  - spi_clk, spi_cs and spi_mosi each pass through a 2-FF synchroniser, then edge detection.
  - Rise/fall/cs events are visible internally 3 clk cycles after the pin changes.
- Reset (rst_n low at a clk edge):
  - Register outputs: spi_miso=1, spi_miso_oe=0, wr_valid=0, wr_addr=0, wr_data=0, abort_cnt=0.
  - State returns to IDLE; all writable registers take RESET_FILL.
  - Reset mid-transfer discards the transfer. The responder only re-arms on the next cs falling edge.
- Command byte: bit7 = RW (1 = read), bit6 = MB (multi-byte), bits5:0 = address.
- Sampling and driving:
  - spi_mosi is sampled on the spi_clk rising edge.
  - spi_miso is updated on the spi_clk falling edge.
- State machine:
  - IDLE -> CMD on cs falling edge. Clear bit counter.
  - CMD: shift 8 bits. On the 8th rise, latch RW, MB and address. Go to RD if RW=1, otherwise WR.
  - RD:
    - On entry, fetch register[addr] into the shift register.
    - Drive bit7 on the first fall after the command, then the remaining bits on each subsequent fall.
    - After the 8th data rise, advance the address and fetch the next byte.
  - WR:
    - Shift 8 bits.
    - On the 8th rise, write register[addr] unless addr == 0.
    - Pulse wr_valid for 1 cycle with wr_addr/wr_data, even when addr == 0 (the write is ignored).
    - Then advance the address.
  - Any state -> IDLE on cs rising edge.
- Address advance:
  - MB=1: addr+1, wrapping modulo 2**ADDR_W (0x3F -> 0x00).
  - MB=0: address held; repeated bytes access the same register.
- spi_miso outside the RD data phase: 1.
- Abort: a cs rise when the bit counter is nonzero (mid-byte) is an abort. A partial write byte is discarded and causes no register change.
- Local update:
  - upd_en writes register[upd_addr] in the same cycle. Ignored for addr 0.
  - If an SPI write to the same address lands in the same cycle, the SPI write wins.
  - An update to a register already fetched for an in-flight read does not alter the bits being shifted.

Optional Feature:
- Macro SPI_RESP_ABORT_CNT_EN.
- Defined:
  - abort_cnt increments on each abort, saturating at 8'hFF.
  - Readable over SPI at address 2**ADDR_W-1, which is read-only; SPI and local writes to it are ignored, but wr_valid still pulses.
- Undefined: abort_cnt is tied to 0, and address 2**ADDR_W-1 is an ordinary register.

Decomposition:
- Package spi_resp_pkg: state encoding (IDLE, CMD, RD, WR), DEVICE_ID default, ADDR_W default, CMD_RW_BIT=7, CMD_MB_BIT=6, ABORT_CNT_ADDR.
- Sub-module spi_resp_sync: 2-FF synchroniser plus rise/fall detect for the three SPI inputs. Outputs clean levels and one-cycle edge strobes.

Test Plan:
- Read ID: after reset, command 0x80, one data byte -> MISO returns 0xE5; wr_valid stays 0.
- Single write/read-back: write 0x2D <- 0x08 (command 0x2D, data 0x08) -> wr_valid pulse with wr_addr=0x2D, wr_data=0x08. Then read command 0xAD -> 0x08.
- Multi-byte with wrap:
  - Local preload 0x3E=0x11, 0x3F=0x22, 0x01=0x33.
  - Command 0xFE, 3 bytes -> 0x11, 0x22, 0xE5.
  - Repeat with MB=0 (command 0xBE), 2 bytes -> 0x11, 0x11.
- Write-protect ID: write 0x00 <- 0x55 -> wr_valid pulses; a later read of 0x00 returns 0xE5.
- Abort:
  - Command 0x10, then raise cs after 4 data bits -> register 0x10 unchanged, no wr_valid.
  - With SPI_RESP_ABORT_CNT_EN: abort_cnt=1, and a read of 0x3F returns 0x01.
- Collision and reset:
  - upd_en to 0x20=0xAA in the same cycle as an SPI write 0x20 <- 0x55 -> register holds 0x55.
  - rst_n low mid-read -> spi_miso_oe=0, responder idle until the next cs fall.
